// File: rtl/jam_cost_server.sv
// Cost-matrix server for the JAM: loads an 8x8 cost table, releases the JAM, serves Cost, captures result.
// Optional JAM_PERM_COUNT_EN adds a saturating perm_count output.
module jam_cost_server #(
    parameter int unsigned TIMEOUT_CYCLES = 1048575,
    parameter int unsigned COST_W         = 7
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [COST_W-1:0] ld_data,
    input  logic              restart,
    output logic              JAM_RST,
    input  logic [2:0]        W,
    input  logic [2:0]        J,
    output logic [COST_W-1:0] Cost,
    input  logic              Valid,
    input  logic [9:0]        MinCost,
    input  logic [3:0]        MatchCount,
    output logic              res_valid,
    output logic [9:0]        res_min_cost,
    output logic [3:0]        res_match_count,
    output logic              timeout
`ifdef JAM_PERM_COUNT_EN
    ,
    output logic [15:0]       perm_count
`endif
);

    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned IDX_W = 6;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_SERVE   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               ld_ready_q, ld_ready_d;
    logic               jam_rst_q, jam_rst_d;
    logic               res_valid_q, res_valid_d;
    logic [9:0]         res_min_q, res_min_d;
    logic [3:0]         res_match_q, res_match_d;
    logic               timeout_q, timeout_d;
    logic               load_we;
    logic [COST_W-1:0]  mem_q [64];
`ifdef JAM_PERM_COUNT_EN
    logic [15:0]        perm_q, perm_d;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wd_d        = wd_q;
        ld_ready_d  = ld_ready_q;
        jam_rst_d   = jam_rst_q;
        res_valid_d = res_valid_q;
        res_min_d   = res_min_q;
        res_match_d = res_match_q;
        timeout_d   = timeout_q;
        load_we     = 1'b0;
`ifdef JAM_PERM_COUNT_EN
        perm_d      = perm_q;
`endif
        case (state_q)
            ST_LOAD: begin
                if (ld_valid && ld_ready_q) begin
                    load_we = 1'b1;
                    if (idx_q == IDX_W'(63)) begin
                        state_d    = ST_RELEASE;
                        ld_ready_d = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_RELEASE: begin
                state_d   = ST_SERVE;
                jam_rst_d = 1'b0;
            end
            ST_SERVE: begin
`ifdef JAM_PERM_COUNT_EN
                if (W == 3'd7 && perm_q != 16'hFFFF) begin
                    perm_d = perm_q + 16'd1;
                end
`endif
                // Valid takes priority over an expiring watchdog
                if (Valid) begin
                    res_valid_d = 1'b1;
                    res_min_d   = MinCost;
                    res_match_d = MatchCount;
                    state_d     = ST_DONE;
                end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    jam_rst_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_DONE: begin
                if (restart) begin
                    state_d     = ST_LOAD;
                    idx_d       = '0;
                    wd_d        = '0;
                    ld_ready_d  = 1'b1;
                    jam_rst_d   = 1'b1;
                    res_valid_d = 1'b0;
                    timeout_d   = 1'b0;
`ifdef JAM_PERM_COUNT_EN
                    perm_d      = '0;
`endif
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_LOAD;
            idx_q       <= '0;
            wd_q        <= '0;
            ld_ready_q  <= 1'b1;
            jam_rst_q   <= 1'b1;
            res_valid_q <= 1'b0;
            res_min_q   <= '0;
            res_match_q <= '0;
            timeout_q   <= 1'b0;
`ifdef JAM_PERM_COUNT_EN
            perm_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wd_q        <= wd_d;
            ld_ready_q  <= ld_ready_d;
            jam_rst_q   <= jam_rst_d;
            res_valid_q <= res_valid_d;
            res_min_q   <= res_min_d;
            res_match_q <= res_match_d;
            timeout_q   <= timeout_d;
`ifdef JAM_PERM_COUNT_EN
            perm_q      <= perm_d;
`endif
        end
    end

    // Cost table storage has no reset; it is always fully reloaded before use
    always_ff @(posedge CLK) begin
        if (load_we) begin
            mem_q[idx_q] <= ld_data;
        end
    end

    // Zero-latency lookup so the JAM can accumulate in the same cycle
    assign Cost            = (state_q == ST_SERVE) ? mem_q[{W, J}] : '0;
    assign ld_ready        = ld_ready_q;
    assign JAM_RST         = jam_rst_q;
    assign res_valid       = res_valid_q;
    assign res_min_cost    = res_min_q;
    assign res_match_count = res_match_q;
    assign timeout         = timeout_q;
`ifdef JAM_PERM_COUNT_EN
    assign perm_count      = perm_q;
`endif

endmodule

// File: tb/tb_jam_cost_server.sv
// Self-checking bench for jam_cost_server: vector table for Cost lookups, scoreboards for Cost and results.
module tb_jam_cost_server;

    localparam int unsigned COST_W = 7;
    localparam int unsigned TMO    = 100;

    logic              CLK, RST_N, ld_valid, ld_ready, restart, JAM_RST;
    logic [COST_W-1:0] ld_data, Cost;
    logic [2:0]        W, J;
    logic              Valid, res_valid, timeout;
    logic [9:0]        MinCost, res_min_cost;
    logic [3:0]        MatchCount, res_match_count;
`ifdef JAM_PERM_COUNT_EN
    logic [15:0]       perm_count;
`endif

    jam_cost_server #(.TIMEOUT_CYCLES(TMO), .COST_W(COST_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .restart(restart), .JAM_RST(JAM_RST), .W(W), .J(J),
        .Cost(Cost), .Valid(Valid), .MinCost(MinCost), .MatchCount(MatchCount),
        .res_valid(res_valid), .res_min_cost(res_min_cost),
        .res_match_count(res_match_count), .timeout(timeout)
`ifdef JAM_PERM_COUNT_EN
        , .perm_count(perm_count)
`endif
    );

    typedef struct { logic [2:0] w; logic [2:0] j; logic [6:0] cost; } vec_t;
    typedef struct { logic [9:0] mc; logic [3:0] cnt; } res_t;

    vec_t              vecs [6];
    logic [6:0]        cost_sb [$];
    res_t              res_sb  [$];
    int                n_checks = 0;
    int                n_fail   = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive n entries starting at value base; optionally check the release timing
    task automatic do_load(input bit gapped, input int n, input int base, input bit full);
        int acc = 0;
        int cyc = 0;
        bit hs;
        while (acc < n && cyc < 2000) begin
            ld_valid = gapped ? ((cyc % 2 == 0) && !(cyc >= 20 && cyc < 30)) : 1'b1;
            ld_data  = COST_W'(base + acc);
            if (full && gapped && acc == 63 && !ld_valid) begin
                check("pre_release_ready", 32'(ld_ready), 32'd1);
                check("pre_release_jamrst", 32'(JAM_RST), 32'd1);
            end
            hs = ld_valid && ld_ready;
            tick();
            if (hs) acc++;
            cyc++;
        end
        ld_valid = 1'b0;
        if (acc < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL load_bound: accepted %0d expected %0d", acc, n);
        end
        if (full) begin
            check("release_ready", 32'(ld_ready), 32'd0);
            check("release_jamrst", 32'(JAM_RST), 32'd1);
            tick();
            check("serve_jamrst", 32'(JAM_RST), 32'd0);
        end
    endtask

    task automatic apply_vectors();
        logic [6:0] e;
        for (int i = 0; i < 6; i++) begin
            W = vecs[i].w;
            J = vecs[i].j;
            cost_sb.push_back(vecs[i].cost);
            #1;
            e = cost_sb.pop_front();
            check("cost_lookup", 32'(Cost), 32'(e));
            tick();
        end
        W = 3'd0;
        J = 3'd0;
    endtask

    task automatic pulse_valid(input logic [9:0] mc, input logic [3:0] cnt);
        res_t r;
        Valid      = 1'b1;
        MinCost    = mc;
        MatchCount = cnt;
        res_sb.push_back('{mc, cnt});
        tick();
        Valid = 1'b0;
        check("res_valid", 32'(res_valid), 32'd1);
        if (res_sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL res_scoreboard: got empty expected entry");
        end else begin
            r = res_sb.pop_front();
            check("res_min_cost", 32'(res_min_cost), 32'(r.mc));
            check("res_match_count", 32'(res_match_count), 32'(r.cnt));
        end
        check("res_timeout", 32'(timeout), 32'd0);
        check("res_jamrst", 32'(JAM_RST), 32'd0);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("restart_jamrst", 32'(JAM_RST), 32'd1);
        check("restart_res_valid", 32'(res_valid), 32'd0);
        check("restart_ready", 32'(ld_ready), 32'd1);
        check("restart_timeout", 32'(timeout), 32'd0);
    endtask

    initial begin
        int n;
        vecs[0] = '{3'd3, 3'd5, 7'd29};
        vecs[1] = '{3'd7, 3'd7, 7'd63};
        vecs[2] = '{3'd0, 3'd0, 7'd0};
        vecs[3] = '{3'd0, 3'd7, 7'd7};
        vecs[4] = '{3'd7, 3'd0, 7'd56};
        vecs[5] = '{3'd4, 3'd2, 7'd34};

        RST_N = 1'b0; ld_valid = 1'b0; ld_data = '0; restart = 1'b0;
        W = 3'd3; J = 3'd5; Valid = 1'b0; MinCost = '0; MatchCount = '0;
        tick();
        tick();
        check("rst_jamrst", 32'(JAM_RST), 32'd1);
        check("rst_ready", 32'(ld_ready), 32'd1);
        check("rst_cost", 32'(Cost), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        RST_N = 1'b1;
        // Valid outside SERVE must be ignored
        Valid = 1'b1; MinCost = 10'd5; MatchCount = 4'd1;
        tick();
        Valid = 1'b0;
        tick();
        tick();
        check("hold_jamrst", 32'(JAM_RST), 32'd1);
        check("hold_ready", 32'(ld_ready), 32'd1);
        check("hold_res_valid", 32'(res_valid), 32'd0);
        check("hold_cost", 32'(Cost), 32'd0);
        W = 3'd0; J = 3'd0;

        // Run 1: gapless load, ignored inputs in SERVE, lookups, result capture
        do_load(1'b0, 64, 0, 1'b1);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("serve_restart_ignored", 32'(JAM_RST), 32'd0);
        ld_valid = 1'b1; ld_data = 7'h7F;
        tick();
        ld_valid = 1'b0;
        check("serve_ready_low", 32'(ld_ready), 32'd0);
        apply_vectors();
        pulse_valid(10'd123, 4'd2);
        Valid = 1'b1; MinCost = 10'd999; MatchCount = 4'd9;
        tick();
        Valid = 1'b0;
        tick();
        check("done_hold_min", 32'(res_min_cost), 32'd123);
        check("done_hold_valid", 32'(res_valid), 32'd1);
        do_restart();

        // Run 2: gapped load must yield the same table
        do_load(1'b1, 64, 0, 1'b1);
`ifdef JAM_PERM_COUNT_EN
        for (int k = 0; k < 5; k++) begin
            W = 3'd7;
            tick();
            W = 3'd0;
            tick();
        end
        check("perm_count", 32'(perm_count), 32'd5);
`endif
        apply_vectors();
        pulse_valid(10'd456, 4'd8);
        do_restart();

        // Run 3: watchdog expiry
        do_load(1'b0, 64, 0, 1'b1);
        n = 0;
        while (!timeout && n < 300) begin
            tick();
            n++;
        end
        check("timeout_cycles", 32'(n), 32'(TMO));
        check("timeout_flag", 32'(timeout), 32'd1);
        check("timeout_jamrst", 32'(JAM_RST), 32'd1);
        check("timeout_res_valid", 32'(res_valid), 32'd0);
        do_restart();

        // Run 4: Valid on the watchdog limit cycle wins
        do_load(1'b0, 64, 0, 1'b1);
        for (int k = 0; k < int'(TMO) - 1; k++) tick();
        pulse_valid(10'd7, 4'd9);
        do_restart();

        // Run 5: reset during a partial load, then a full reload from index 0
        do_load(1'b0, 30, 64, 1'b0);
        RST_N = 1'b0;
        #1;
        check("midload_rst_jamrst", 32'(JAM_RST), 32'd1);
        check("midload_rst_ready", 32'(ld_ready), 32'd1);
        tick();
        RST_N = 1'b1;
        do_load(1'b0, 64, 0, 1'b1);
        apply_vectors();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
